// File: rtl/bin2rns_pkg.sv
// Shared constants and FSM state type for the 16-bit binary to RNS {32,31,21,5} converter.
package bin2rns_pkg;

    localparam int DYN_SIZE = 16;
    localparam int CNT_W    = 4;
    localparam int MAX_MOD  = 5;

    localparam int MOD_1   = 32;
    localparam int MOD_1_K = 5;
    localparam int MOD_2   = 31;
    localparam int MOD_2_W = 5;
    localparam int MOD_3   = 21;
    localparam int MOD_3_W = 5;
    localparam int MOD_4   = 5;
    localparam int MOD_4_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/bin2rns_32_31_21_5_mod_serial_acc.sv
// Bit-serial MSB-first modular accumulator: r <- (2r + b) mod M, one bit per enabled cycle.
// Because r < M holds before every step, 2r + b < 2M and one conditional subtract is enough.
// r_next exposes the value the accumulator takes on the next enabled edge, so the parent
// can capture the final residue on the same edge that consumes the last bit.
module mod_serial_acc #(
    parameter int M = 31,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic         bit_in,
    output logic [W-1:0] r,
    output logic [W-1:0] r_next
);

    localparam logic [W:0] M_L = (W+1)'(M);

    logic [W:0] t;

    // Doubling plus incoming bit, then a single conditional subtract of M.
    always_comb begin
        t      = {r, bit_in};
        r_next = (t >= M_L) ? W'(t - M_L) : W'(t);
    end

    // Accumulator register: cleared on operand accept, stepped during conversion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r <= '0;
        end else if (clr) begin
            r <= '0;
        end else if (en) begin
            r <= r_next;
        end
    end

endmodule

// File: rtl/bin2rns_32_31_21_5.sv
// Forward converter: 16-bit unsigned word to residues mod {32, 31, 21, 5}.
// Handshake rule (both sides): a transfer happens on a rising edge where valid and ready
// are both 1; the source keeps data and valid stable until then.
// Input side: in_ready is high only in IDLE; in_valid elsewhere is ignored, never queued.
// Output side: out_valid rises 16 edges after accept and x0..x3 stay stable until
// out_ready is seen; x0..x3 then keep their last value until the next result.
module bin2rns_32_31_21_5
    import bin2rns_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [DYN_SIZE-1:0] N,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [MAX_MOD-1:0]  x0,
    output logic [MAX_MOD-1:0]  x1,
    output logic [MAX_MOD-1:0]  x2,
    output logic [MAX_MOD-1:0]  x3,
    output logic                out_valid,
    input  logic                out_ready
);

    state_t               state, state_nxt;
    logic [DYN_SIZE-1:0]  shreg;
    logic [CNT_W-1:0]     cnt;
    logic [MOD_1_K-1:0]   x0_acc;
    logic [MOD_2_W-1:0]   r2, r2_next;
    logic [MOD_3_W-1:0]   r3, r3_next;
    logic [MOD_4_W-1:0]   r4, r4_next;
    logic                 accept, converting, last_step;

    assign accept     = (state == IDLE) && in_valid;
    assign converting = (state == CONVERT);
    assign last_step  = converting && (cnt == CNT_W'(DYN_SIZE - 1));
    assign in_ready   = (state == IDLE);

    // Next-state logic for IDLE -> CONVERT -> HOLD -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CONVERT;
            CONVERT: if (last_step) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand shift register (MSB out first), bit counter and the power-of-two residue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg  <= '0;
            cnt    <= '0;
            x0_acc <= '0;
        end else if (accept) begin
            shreg  <= N;
            cnt    <= '0;
            x0_acc <= N[MOD_1_K-1:0];
        end else if (converting) begin
            shreg  <= {shreg[DYN_SIZE-2:0], 1'b0};
            cnt    <= cnt + 1'b1;
        end
    end

    mod_serial_acc #(.M(MOD_2), .W(MOD_2_W)) u_acc_31 (
        .clk(clk), .reset(reset), .clr(accept), .en(converting),
        .bit_in(shreg[DYN_SIZE-1]), .r(r2), .r_next(r2_next)
    );

    mod_serial_acc #(.M(MOD_3), .W(MOD_3_W)) u_acc_21 (
        .clk(clk), .reset(reset), .clr(accept), .en(converting),
        .bit_in(shreg[DYN_SIZE-1]), .r(r3), .r_next(r3_next)
    );

    mod_serial_acc #(.M(MOD_4), .W(MOD_4_W)) u_acc_5 (
        .clk(clk), .reset(reset), .clr(accept), .en(converting),
        .bit_in(shreg[DYN_SIZE-1]), .r(r4), .r_next(r4_next)
    );

    // Output registers: load only on the HOLD-entry edge, clear out_valid on consumer take.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x0        <= '0;
            x1        <= '0;
            x2        <= '0;
            x3        <= '0;
            out_valid <= 1'b0;
        end else if (last_step) begin
            x0        <= x0_acc;
            x1        <= r2_next;
            x2        <= r3_next;
            x3        <= {{(MAX_MOD - MOD_4_W){1'b0}}, r4_next};
            out_valid <= 1'b1;
        end else if ((state == HOLD) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bin2rns_32_31_21_5.sv
// Directed plus randomized bench for bin2rns_32_31_21_5 against a plain modulo reference.
module tb_bin2rns_32_31_21_5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] n_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  x0, x1, x2, x3;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    bin2rns_32_31_21_5 dut (
        .clk(clk), .reset(reset), .N(n_in), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for IDLE, present n, leave it for one accepting edge.
    task automatic send(input logic [15:0] n);
        int k = 0;
        while (!in_ready && k < 60) begin
            step();
            k++;
        end
        chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        n_in     = n;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_in     = $urandom_range(0, 65535);
    endtask

    // Full transaction: latency, in_ready low, residues vs model, hold stability, release.
    task automatic run_one(input logic [15:0] n, input int hold_cycles, input bit poke_in_hold);
        int  lat = 0;
        bit  rdy_seen = 1'b0;
        bit  stable = 1'b1;
        logic [4:0] e0, e1, e2, e3;
        e0 = 5'(n % 32);
        e1 = 5'(n % 31);
        e2 = 5'(n % 21);
        e3 = 5'(n % 5);
        send(n);
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_seen = 1'b1;
            step();
            lat++;
        end
        chk("latency", lat, 16);
        chk("in_ready_low_during_convert", {31'd0, rdy_seen}, 32'd0);
        chk("out_valid", {31'd0, out_valid}, 32'd1);
        chk("x0", x0, e0);
        chk("x1", x1, e1);
        chk("x2", x2, e2);
        chk("x3", x3, e3);
        for (int i = 0; i < hold_cycles; i++) begin
            if (poke_in_hold && i == 2) begin
                n_in     = 16'd999;
                in_valid = 1'b1;
            end
            step();
            if (!out_valid || in_ready || x0 !== e0 || x1 !== e1 || x2 !== e2 || x3 !== e3)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        if (hold_cycles > 0) chk("hold_stable", {31'd0, stable}, 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid_cleared", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after_take", {31'd0, in_ready}, 32'd1);
        chk("x_kept_after_take", {12'd0, x0, x1, x2, x3}, {12'd0, e0, e1, e2, e3});
    endtask

    // Stimulus sequence.
    initial begin
        bit pulse = 1'b0;
        reset = 1'b0;
        repeat (3) step();
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_x", {12'd0, x0, x1, x2, x3}, 32'd0);
        reset = 1'b1;
        step();
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        run_one(16'd0, 0, 1'b0);
        run_one(16'd65535, 0, 1'b0);
        run_one(16'd12345, 10, 1'b1);
        run_one(16'd41, 0, 1'b0);
        run_one(16'd1000, 0, 1'b0);

        // Reset in the middle of a conversion discards the result.
        send(16'd777);
        repeat (7) step();
        reset = 1'b0;
        #1;
        chk("midreset_x", {12'd0, x0, x1, x2, x3}, 32'd0);
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) pulse = 1'b1;
        end
        chk("midreset_no_pulse", {31'd0, pulse}, 32'd0);
        run_one(16'd100, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            run_one(16'($urandom_range(0, 65535)), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
